mem_stage_lsu: RTL

//  Memory-access stage between execute and writeback; decodes mem_read/mem_write/funct3 from the control word.

---
 rtl/mem_stage_lsu.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu
//   Memory-access pipeline stage between execute and writeback.
//   Decodes mem_read / mem_write / funct3 from the control word, checks
//   alignment, lane-replicates store data and builds byte enables, runs a
//   request/response handshake with the data cache while stalling upstream,
//   then sign/zero-extends load data for writeback. A saturating counter
//   records every cycle in which the stage stalls upstream.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   ex_valid            instruction valid at stage input
//   ex_mem_read/write   control-word memory op flags (read has priority)
//   ex_funct3           load/store width encoding
//   ex_addr, ex_wdata   effective address and store source
//   stall_o             hold upstream stages this cycle (combinational)
//   wb_valid, wb_rdata  one-cycle result pulse toward writeback
//   misalign_o          one-cycle pulse: misaligned or illegal-funct3 mem op
//   dmem_*              registered cache request; dmem_resp/dmem_rdata reply
//   stall_cycles        saturating count of cycles with stall_o high
// -----------------------------------------------------------------------------
module mem_stage_lsu #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic             ex_mem_write,
  input  logic [2:0]       ex_funct3,
  input  logic [31:0]      ex_addr,
  input  logic [31:0]      ex_wdata,
  output logic             stall_o,
  output logic             wb_valid,
  output logic [31:0]      wb_rdata,
  output logic             misalign_o,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic [31:0]      dmem_address,
  output logic [31:0]      dmem_wdata,
  output logic [3:0]       dmem_byte_enable,
  input  logic             dmem_resp,
  input  logic [31:0]      dmem_rdata,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t      state_q, state_d;
  logic        accept;
  logic        legal;
  logic        addr_ok;
  logic        aligned;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign accept = (state_q == IDLE) && ex_valid && (ex_mem_read || ex_mem_write);

  // Decode legality and natural alignment of the incoming op.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    legal   = 1'b0;
    addr_ok = 1'b0;
    st_data = ex_wdata;
    st_be   = 4'b1111;
    if (ex_mem_read) begin
      legal = (ex_funct3 == F3_B) || (ex_funct3 == F3_H) || (ex_funct3 == F3_W) ||
              (ex_funct3 == F3_BU) || (ex_funct3 == F3_HU);
    end else begin
      legal = (ex_funct3 == F3_B) || (ex_funct3 == F3_H) || (ex_funct3 == F3_W);
    end
    case (ex_funct3[1:0])
      2'b00:   addr_ok = 1'b1;
      2'b01:   addr_ok = ~ex_addr[0];
      2'b10:   addr_ok = (ex_addr[1:0] == 2'b00);
      default: addr_ok = 1'b0;
    endcase
    // Stores replicate the source across lanes; the byte enable picks the lane.
    if (!ex_mem_read) begin
      case (ex_funct3[1:0])
        2'b00: begin
          st_data = {4{ex_wdata[7:0]}};
          st_be   = 4'b0001 << ex_addr[1:0];
        end
        2'b01: begin
          st_data = {2{ex_wdata[15:0]}};
          st_be   = 4'b0011 << ex_addr[1:0];
        end
        default: begin
          st_data = ex_wdata;
          st_be   = 4'b1111;
        end
      endcase
    end
  end

  assign aligned = legal && addr_ok;

  // Stall while an accepted op waits for the cache; the response cycle itself
  // lets upstream advance. Held low during reset so nothing upstream freezes.
  assign stall_o = ~rst && ((accept && aligned) || ((state_q == BUSY) && ~dmem_resp));

  // Load lane select using the offset captured at accept time.
  always_comb begin
    ld_byte = dmem_rdata[7:0];
    case (off_q)
      2'd0:    ld_byte = dmem_rdata[7:0];
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_q)
      F3_B:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_ext = {{16{ld_half[15]}}, ld_half};
      F3_W:    ld_ext = dmem_rdata;
      F3_BU:   ld_ext = {24'd0, ld_byte};
      F3_HU:   ld_ext = {16'd0, ld_half};
      default: ld_ext = 32'd0;
    endcase
  end

  // Next-state logic. A response seen in IDLE is ignored; ex_* is ignored in BUSY.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && aligned) state_d = BUSY;
      BUSY:    if (dmem_resp)         state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every register here is reset, including the latched request fields,
  // so the cache interface is fully defined straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_read        <= 1'b0;
      dmem_write       <= 1'b0;
      dmem_address     <= 32'd0;
      dmem_wdata       <= 32'd0;
      dmem_byte_enable <= 4'd0;
      funct3_q         <= 3'd0;
      off_q            <= 2'd0;
      wb_valid         <= 1'b0;
      wb_rdata         <= 32'd0;
      misalign_o       <= 1'b0;
      stall_cycles     <= '0;
    end else begin
      wb_valid   <= 1'b0;
      wb_rdata   <= 32'd0;
      misalign_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept && aligned) begin
            dmem_read        <= ex_mem_read;
            dmem_write       <= ~ex_mem_read & ex_mem_write;
            dmem_address     <= {ex_addr[31:2], 2'b00};
            dmem_wdata       <= st_data;
            dmem_byte_enable <= st_be;
            funct3_q         <= ex_funct3;
            off_q            <= ex_addr[1:0];
          end else if (ex_valid) begin
            // Misaligned/illegal mem ops and non-mem ops pass straight through.
            wb_valid   <= 1'b1;
            misalign_o <= accept;
          end
        end
        BUSY: begin
          if (dmem_resp) begin
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            wb_valid   <= 1'b1;
            wb_rdata   <= dmem_read ? ld_ext : 32'd0;
          end
        end
        default: ;
      endcase
      if (stall_o && !(&stall_cycles)) stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule
